regfile_mp: RTL and testbench
=============================

# regfile_mp

Parametrised multi-port register file for the CPU datapath, the successor to the fixed 32x32 two-read-port file. It provides a configurable number of registered read ports, one write port, and an optional hard-wired zero register. A multi-cycle soft-clear sweep is driven by a small state machine, and a combinational debug port replaces the per-register output buses. It sits between decode (read addresses) and writeback (write port) in the pipeline.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, when 1 entry 0 always reads 0 and ignores writes

Ports:
- Clk  in  1  clock; all state changes on the rising edge
- Rst  in  1  asynchronous, active-low reset (asserted when 0)
- RA  in  NUM_RD*ADDR_W  read addresses; port p uses bits [p*ADDR_W +: ADDR_W]
- BusR  out  NUM_RD*DATA_W  registered read data; port p uses bits [p*DATA_W +: DATA_W]
- RW  in  ADDR_W  write address
- BusW  in  DATA_W  write data
- RegWr  in  1  write enable
- Clr  in  1  soft-clear request, single-cycle pulse
- Busy  out  1  high while the clear sweep is running
- Done  out  1  one-cycle pulse when the sweep completes
- DbgAddr  in  ADDR_W  debug read address
- DbgData  out  DATA_W  combinational contents of entry DbgAddr (no bypass)

## Operation
- **Reset** (Rst=0, async): all entries are 0, BusR is 0, Busy is 0, Done is 0, FSM is IDLE, clear pointer is 0.
- **Write:** on a rising edge with RegWr=1, entry RW gets BusW. If ZERO_REG=1 and RW=0, the write is dropped.
- **Read:** on every rising edge, each port p latches entry RA[p] into BusR[p]. There is no read enable; the output holds until the next edge.
- **Zero register:** with ZERO_REG=1, a read of address 0 always returns 0.
- **Clear FSM, IDLE:**
  - Clr=1 moves the FSM to SWEEP and sets the pointer to 0.
  - Clr=0 keeps the FSM in IDLE.
- **Clear FSM, SWEEP:**
  - Each cycle, entry[ptr] is set to 0 and ptr increments.
  - When ptr=DEPTH-1 is cleared, the FSM returns to IDLE and Done pulses for one cycle.
  - Clr is ignored in SWEEP (no restart, no queueing).
- **Write/sweep same entry, same edge:** the write wins, so the entry holds BusW.
- **Read during sweep:** returns the entry value before the edge, or the bypassed value when REGFILE_BYPASS_EN is defined. Not-yet-swept entries return their old contents.
- **Writes during SWEEP:** accepted normally. A write to an entry already swept persists.
- **Reset mid-sweep:** the FSM aborts to IDLE, all entries go to 0, and Done is not pulsed.
- **DbgAddr:** purely combinational view of array contents; it does not affect any state.

## Timing
- **Read latency:** 1 cycle. RA sampled at edge k gives BusR valid after edge k, stable until edge k+1.
- **Write latency:** 1 cycle. Without bypass, a read at edge k+1 or later sees the write from edge k.
- **Sweep duration:** Clr seen at edge k sets Busy=1 after edge k. Entries 0..DEPTH-1 are cleared at edges k+1..k+DEPTH. After edge k+DEPTH, Busy=0 and Done=1; Done returns to 0 after edge k+DEPTH+1.
- **Clr on the completing edge:** a Clr on the same edge that completes a sweep is ignored.
- **Back-to-back sweeps:** a Clr on edge k+DEPTH+1 or later starts a new sweep.

## Configuration
- **Macro REGFILE_BYPASS_EN, defined:** write-to-read forwarding. On an edge where RegWr=1 and RW==RA[p] (and the write is not dropped for address 0), BusR[p] gets BusW instead of the stale entry. Forwarding is applied independently per port and overrides a same-edge sweep of that address.
- **Macro REGFILE_BYPASS_EN, not defined:** BusR[p] returns the pre-edge entry value. Software or hazard logic must insert one bubble between a write and a dependent read.

## Structure
- **Shared package `regfile_pkg`:**
  - Default width constants: REGFILE_DATA_W=32, REGFILE_ADDR_W=5.
  - FSM state typedef `clr_state_t` with states IDLE and SWEEP.
- **Sub-module `regfile_rdport`:** one instance per read port via generate. It contains the address-0 masking, the optional bypass mux, and the output register.
- **Top-level `regfile_mp`:** owns the array, the write logic, the clear FSM/pointer, and the debug port.

## Test plan
- **Reset:** hold Rst=0 with random RA and RegWr=1. Required: BusR=0, Busy=0, Done=0, DbgData=0 for all DbgAddr. Release Rst, write 0xDEADBEEF to entry 7, read RA[0]=7 two cycles later. Required: 0xDEADBEEF.
- **Zero register:** write 0x12345678 to RW=0 with ZERO_REG=1. Required: a read of port 0 and port 1 at address 0 returns 0x0, and DbgData at address 0 is 0.
- **Bypass:** RegWr=1, RW=5, BusW=0xA5A5A5A5, RA[1]=5 on the same edge. Required: BusR[1]=0xA5A5A5A5 with REGFILE_BYPASS_EN defined, old value 0x0 without it.
- **Sweep:** fill all entries with 0xFFFFFFFF, then pulse Clr at edge k. Required: Busy=1 for DEPTH cycles, Done=1 exactly after edge k+DEPTH, all DbgData=0.
- **Write during sweep:** pulse Clr, then on edge k+2 (entry 1 cleared at k+2) write 0x55 to entry 1 and 0x66 to entry 20. Required: after Done, entry 1 = 0x55 and entry 20 = 0. A second Clr during Busy is ignored (Busy length unchanged).
- **Reset mid-sweep:** drive Rst=0 at cycle k+10 of a sweep. Required: Busy drops immediately, Done is never pulsed, all entries are 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants and types for the multi-port register file.
package regfile_pkg;

  localparam int unsigned REGFILE_DATA_W = 32;
  localparam int unsigned REGFILE_ADDR_W = 5;
  localparam int unsigned REGFILE_NUM_RD = 2;

  typedef enum logic {
    IDLE  = 1'b0,
    SWEEP = 1'b1
  } clr_state_t;

endpackage

// File: rtl/regfile_mp_if.sv
// Decode/writeback-facing bus of the register file: read/write ports, clear handshake, debug view.
interface regfile_mp_if
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W = REGFILE_DATA_W,
  parameter int unsigned ADDR_W = REGFILE_ADDR_W,
  parameter int unsigned NUM_RD = REGFILE_NUM_RD
);

  logic [NUM_RD*ADDR_W-1:0] RA;
  logic [NUM_RD*DATA_W-1:0] BusR;
  logic [ADDR_W-1:0]        RW;
  logic [DATA_W-1:0]        BusW;
  logic                     RegWr;
  logic                     Clr;
  logic                     Busy;
  logic                     Done;
  logic [ADDR_W-1:0]        DbgAddr;
  logic [DATA_W-1:0]        DbgData;

  modport master (
    output RA, RW, BusW, RegWr, Clr, DbgAddr,
    input  BusR, Busy, Done, DbgData
  );

  modport slave (
    input  RA, RW, BusW, RegWr, Clr, DbgAddr,
    output BusR, Busy, Done, DbgData
  );

endinterface

// File: rtl/regfile_rdport.sv
// One registered read port: address-0 masking, optional write forwarding, output register.
// Forwarding is compiled in when REGFILE_BYPASS_EN is defined.
module regfile_rdport
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = REGFILE_DATA_W,
  parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic                                  Clk,
  input  logic                                  Rst,
  input  logic [ADDR_W-1:0]                     addr_i,
  input  logic [(2**ADDR_W)-1:0][DATA_W-1:0]    mem_i,
  input  logic                                  wr_en_i,
  input  logic [ADDR_W-1:0]                     wr_addr_i,
  input  logic [DATA_W-1:0]                     wr_data_i,
  output logic [DATA_W-1:0]                     rd_data_o
);

  logic [DATA_W-1:0] rd_d;
  logic [DATA_W-1:0] rd_q;

`ifdef REGFILE_BYPASS_EN
  logic fwd_hit_c;

  // A same-edge write to the addressed entry is forwarded unless it is a dropped write to r0.
  always_comb begin
    fwd_hit_c = wr_en_i && (wr_addr_i == addr_i) &&
                !((ZERO_REG != 0) && (wr_addr_i == '0));
  end
`else
  logic unused_bypass_c;
  assign unused_bypass_c = ^{wr_en_i, wr_addr_i, wr_data_i};
`endif

  always_comb begin
    rd_d = mem_i[addr_i];
    if ((ZERO_REG != 0) && (addr_i == '0)) begin
      rd_d = '0;
    end
`ifdef REGFILE_BYPASS_EN
    if (fwd_hit_c) begin
      rd_d = wr_data_i;
    end
`endif
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      rd_q <= '0;
    end else begin
      rd_q <= rd_d;
    end
  end

  assign rd_data_o = rd_q;

endmodule

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file with soft-clear sweep FSM and combinational debug view.
// Optional write-to-read forwarding in the read ports is enabled by defining REGFILE_BYPASS_EN.
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W   = REGFILE_DATA_W,
  parameter int unsigned ADDR_W   = REGFILE_ADDR_W,
  parameter int unsigned NUM_RD   = REGFILE_NUM_RD,
  parameter int unsigned ZERO_REG = 1
) (
  input  logic         Clk,
  input  logic         Rst,
  regfile_mp_if.slave  bus
);

  localparam int unsigned DEPTH = 2**ADDR_W;

  clr_state_t                      state_q, state_d;
  logic [ADDR_W-1:0]               ptr_q, ptr_d;
  logic                            done_q, done_d;
  logic [DEPTH-1:0][DATA_W-1:0]    mem_q, mem_d;
  logic                            sweep_c;
  logic                            wr_ok_c;
  logic [NUM_RD-1:0][DATA_W-1:0]   rd_data;

  // Clear sweep: one entry per cycle, Clr ignored while sweeping.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    done_d  = 1'b0;
    sweep_c = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.Clr) begin
          state_d = SWEEP;
          ptr_d   = '0;
        end
      end
      SWEEP: begin
        sweep_c = 1'b1;
        if (ptr_q == ADDR_W'(DEPTH - 1)) begin
          state_d = IDLE;
          ptr_d   = '0;
          done_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + ADDR_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  // Array update; the write is applied after the sweep so it wins on a shared entry.
  always_comb begin
    wr_ok_c = bus.RegWr && !((ZERO_REG != 0) && (bus.RW == '0));
    mem_d   = mem_q;
    if (sweep_c) begin
      mem_d[ptr_q] = '0;
    end
    if (wr_ok_c) begin
      mem_d[bus.RW] = bus.BusW;
    end
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      done_q  <= 1'b0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      done_q  <= done_d;
      mem_q   <= mem_d;
    end
  end

  for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
    regfile_rdport #(
      .DATA_W   (DATA_W),
      .ADDR_W   (ADDR_W),
      .ZERO_REG (ZERO_REG)
    ) u_rdport (
      .Clk       (Clk),
      .Rst       (Rst),
      .addr_i    (bus.RA[p*ADDR_W +: ADDR_W]),
      .mem_i     (mem_q),
      .wr_en_i   (bus.RegWr),
      .wr_addr_i (bus.RW),
      .wr_data_i (bus.BusW),
      .rd_data_o (rd_data[p])
    );
  end

  assign bus.BusR    = rd_data;
  assign bus.Busy    = (state_q == SWEEP);
  assign bus.Done    = done_q;
  assign bus.DbgData = mem_q[bus.DbgAddr];

endmodule

// File: tb/tb_regfile_mp.sv
// Randomised and directed bench for regfile_mp against an edge-indexed behavioural model.
module tb_regfile_mp;

  localparam int unsigned DW    = 32;
  localparam int unsigned AW    = 5;
  localparam int unsigned NR    = 2;
  localparam int unsigned DEPTH = 32;
  localparam int unsigned RAW   = NR * AW;

  logic Clk;
  logic Rst;
  int   errors = 0;
  int   checks = 0;

  regfile_mp_if #(.DATA_W(DW), .ADDR_W(AW), .NUM_RD(NR)) bus ();

  regfile_mp #(
    .DATA_W   (DW),
    .ADDR_W   (AW),
    .NUM_RD   (NR),
    .ZERO_REG (1)
  ) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Behavioural model: sweep position derived from the edge count since Clr was accepted.
  logic [DW-1:0] m_mem [DEPTH];
  logic [DW-1:0] m_rd  [NR];
  logic          m_busy;
  logic          m_done;
  int            edge_n  = 0;
  int            sweep_k = 0;

  // Busy-run monitor used by the directed sweep checks
  int   busy_run     = 0;
  int   last_run     = 0;
  int   done_cnt     = 0;
  logic done_at_fall = 1'b0;

  function automatic void chk(string nm, logic [DW-1:0] act, logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] busr(int p);
    return bus.BusR[p*DW +: DW];
  endfunction

  task automatic model_edge();
    logic [AW-1:0] a;
    logic          wr_ok;
    int            j;
    if (!Rst) begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = '0;
      for (int p = 0; p < NR; p++) m_rd[p] = '0;
      m_busy = 1'b0;
      m_done = 1'b0;
    end else if (Clk) begin
      edge_n++;
      wr_ok = bus.RegWr && (bus.RW != '0);
      for (int p = 0; p < NR; p++) begin
        a = bus.RA[p*AW +: AW];
        m_rd[p] = (a == '0) ? '0 : m_mem[a];
`ifdef REGFILE_BYPASS_EN
        if (wr_ok && (bus.RW == a)) m_rd[p] = bus.BusW;
`endif
      end
      m_done = 1'b0;
      if (m_busy) begin
        j = edge_n - sweep_k - 1;
        m_mem[AW'(j)] = '0;
        if (j == DEPTH - 1) begin
          m_busy = 1'b0;
          m_done = 1'b1;
        end
      end else if (bus.Clr) begin
        m_busy  = 1'b1;
        sweep_k = edge_n;
      end
      if (wr_ok) m_mem[bus.RW] = bus.BusW;
    end
  endtask

  task automatic monitor_tick();
    if (bus.Busy) begin
      busy_run++;
    end else begin
      if (busy_run != 0) begin
        last_run     = busy_run;
        done_at_fall = bus.Done;
      end
      busy_run = 0;
    end
    if (bus.Done) done_cnt++;
  endtask

  task automatic compare_all();
    for (int p = 0; p < NR; p++) chk($sformatf("busr%0d", p), busr(p), m_rd[p]);
    chk("busy", DW'(bus.Busy), DW'(m_busy));
    chk("done", DW'(bus.Done), DW'(m_done));
    chk("dbgdata", bus.DbgData, m_mem[bus.DbgAddr]);
  endtask

  always @(posedge Clk or negedge Rst) model_edge();

  always @(negedge Clk) begin
    compare_all();
    monitor_tick();
  end

  task automatic cyc();
    @(posedge Clk);
    #2;
  endtask

  task automatic set_ra(int p, logic [AW-1:0] a);
    bus.RA[p*AW +: AW] = a;
  endtask

  task automatic quiet();
    bus.RegWr = 1'b0;
    bus.Clr   = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    quiet();
    while (bus.Busy && n < 100) begin
      cyc();
      n++;
    end
    chk("idle_timeout", DW'(bus.Busy), '0);
  endtask

  task automatic fill_all(logic [DW-1:0] v);
    for (int i = 0; i < DEPTH; i++) begin
      bus.RegWr = 1'b1;
      bus.RW    = AW'(i);
      bus.BusW  = v;
      cyc();
    end
    bus.RegWr = 1'b0;
  endtask

  task automatic check_all_zero(string nm);
    quiet();
    for (int i = 0; i < DEPTH; i++) begin
      bus.DbgAddr = AW'(i);
      @(negedge Clk);
      chk(nm, bus.DbgData, '0);
      cyc();
    end
  endtask

  task automatic random_phase(int n);
    for (int c = 0; c < n; c++) begin
      bus.RegWr   = 1'($urandom);
      bus.RW      = AW'($urandom);
      bus.BusW    = $urandom;
      bus.RA      = RAW'($urandom);
      bus.DbgAddr = AW'($urandom);
      bus.Clr     = ($urandom_range(0, 49) == 0);
      for (int p = 0; p < NR; p++)
        if ($urandom_range(0, 3) == 0) set_ra(p, bus.RW);
      cyc();
    end
    quiet();
  endtask

  initial begin
    int snap;
    Rst         = 1'b1;
    bus.RA      = '0;
    bus.RW      = '0;
    bus.BusW    = '0;
    bus.RegWr   = 1'b0;
    bus.Clr     = 1'b0;
    bus.DbgAddr = '0;
    #1 Rst = 1'b0;

    // Reset held with random traffic: everything must read zero
    for (int i = 0; i < DEPTH; i++) begin
      cyc();
      bus.RA      = RAW'($urandom);
      bus.RegWr   = 1'b1;
      bus.RW      = AW'($urandom);
      bus.BusW    = $urandom;
      bus.Clr     = 1'($urandom);
      bus.DbgAddr = AW'(i);
      @(negedge Clk);
      chk("rst_dbg", bus.DbgData, '0);
    end
    chk("rst_busy", DW'(bus.Busy), '0);
    chk("rst_busr1", busr(1), '0);

    cyc();
    Rst = 1'b1;
    bus.Clr   = 1'b0;
    bus.RegWr = 1'b1;
    bus.RW    = AW'(7);
    bus.BusW  = 32'hDEADBEEF;
    cyc();
    bus.RegWr = 1'b0;
    cyc();
    set_ra(0, AW'(7));
    cyc();
    @(negedge Clk);
    chk("read_after_write", busr(0), 32'hDEADBEEF);

    // Same-edge write and read of entry 5 (still zero from reset)
    cyc();
    bus.RegWr = 1'b1;
    bus.RW    = AW'(5);
    bus.BusW  = 32'hA5A5A5A5;
    set_ra(1, AW'(5));
    set_ra(0, AW'(3));
    cyc();
    bus.RegWr = 1'b0;
    @(negedge Clk);
`ifdef REGFILE_BYPASS_EN
    chk("bypass", busr(1), 32'hA5A5A5A5);
`else
    chk("no_bypass", busr(1), 32'h0);
`endif

    // Zero register ignores writes
    cyc();
    bus.RegWr = 1'b1;
    bus.RW    = '0;
    bus.BusW  = 32'h12345678;
    cyc();
    bus.RegWr   = 1'b0;
    bus.RA      = '0;
    bus.DbgAddr = '0;
    cyc();
    @(negedge Clk);
    chk("zero_p0", busr(0), '0);
    chk("zero_p1", busr(1), '0);
    chk("zero_dbg", bus.DbgData, '0);

    random_phase(400);
    wait_idle();

    // Full sweep over a filled array
    fill_all('1);
    bus.Clr = 1'b1;
    snap = done_cnt;
    cyc();
    bus.Clr = 1'b0;
    wait_idle();
    cyc();
    chk("sweep_len", DW'(last_run), DW'(DEPTH));
    chk("sweep_done_at_fall", DW'(done_at_fall), 32'd1);
    chk("sweep_done_cnt", DW'(done_cnt - snap), 32'd1);
    check_all_zero("sweep_clear");

    // Writes during a sweep, plus an ignored second Clr
    fill_all('1);
    bus.Clr = 1'b1;
    cyc();
    bus.Clr = 1'b0;
    cyc();
    bus.RegWr = 1'b1;
    bus.RW    = AW'(1);
    bus.BusW  = 32'h55;
    cyc();
    bus.RW    = AW'(20);
    bus.BusW  = 32'h66;
    cyc();
    bus.RegWr = 1'b0;
    bus.Clr   = 1'b1;
    cyc();
    bus.Clr = 1'b0;
    wait_idle();
    cyc();
    chk("wsweep_len", DW'(last_run), DW'(DEPTH));
    bus.DbgAddr = AW'(1);
    @(negedge Clk);
    chk("wsweep_e1", bus.DbgData, 32'h55);
    cyc();
    bus.DbgAddr = AW'(20);
    @(negedge Clk);
    chk("wsweep_e20", bus.DbgData, 32'h0);

    // Reset in the middle of a sweep
    cyc();
    fill_all('1);
    bus.Clr = 1'b1;
    cyc();
    bus.Clr = 1'b0;
    repeat (9) cyc();
    chk("midsweep_busy_before", DW'(bus.Busy), 32'd1);
    snap = done_cnt;
    Rst = 1'b0;
    #1;
    chk("midsweep_busy_drop", DW'(bus.Busy), '0);
    repeat (3) cyc();
    Rst = 1'b1;
    repeat (40) cyc();
    chk("midsweep_no_done", DW'(done_cnt - snap), '0);
    check_all_zero("midsweep_clear");

    random_phase(200);
    wait_idle();
    cyc();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
